// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: request/result bundle between the EX stage and the multiply/divide sequencer
interface muldiv_sequencer_if #(
   parameter int WIDTH = 32,
   parameter int Flag_Width = 3
);
   logic start;
   logic flush;
   logic [1:0] MDCon;
   logic [WIDTH-1:0] DataA;
   logic [WIDTH-1:0] DataB;
   logic busy;
   logic done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [Flag_Width-1:0] Flag;
   modport master (output start, flush, MDCon, DataA, DataB, input busy, done, hi, lo, Flag);
   modport slave (input start, flush, MDCon, DataA, DataB, output busy, done, hi, lo, Flag);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: 32-cycle shift-add multiply / restoring divide sharing one (WIDTH+1)-bit adder, holding HI/LO
module muldiv_sequencer #(
   parameter int WIDTH = 32,
   parameter int Flag_Width = 3
) (
   input logic clk,
   input logic reset,
   muldiv_sequencer_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
   state_t state;
   logic [CW-1:0] counter;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0] b;
   logic mul, sa, sb, dz, ov, sgn;
   logic [WIDTH-1:0] abs_a, abs_b, quo, rem, rsrc;
   logic [WIDTH:0] x, sum;
   logic [2*WIDTH-1:0] prod;
   assign sgn = !bus.MDCon[0];
   assign abs_a = sgn && bus.DataA[WIDTH-1] ? -bus.DataA : bus.DataA;
   assign abs_b = sgn && bus.DataB[WIDTH-1] ? -bus.DataB : bus.DataB;
   // multiply adds into the upper half; divide subtracts from {remainder, next dividend bit}
   assign x = mul ? {1'b0, acc[2*WIDTH-1:WIDTH]} : acc[2*WIDTH-1:WIDTH-1];
   assign sum = mul ? x + {1'b0, acc[0] ? b : {WIDTH{1'b0}}} : x - {1'b0, b};
   assign prod = sa ^ sb ? -acc : acc;
   assign quo = dz ? {WIDTH{1'b1}} : (sa ^ sb ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
   // on divide-by-zero the untouched |dividend| re-signed gives back DataA
   assign rsrc = dz ? acc[WIDTH-1:0] : acc[2*WIDTH-1:WIDTH];
   assign rem = sa ? -rsrc : rsrc;
   assign bus.busy = state != IDLE;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         counter <= '0;
         bus.done <= 1'b0;
         bus.hi <= '0;
         bus.lo <= '0;
         bus.Flag <= '0;
      end else begin
         bus.done <= 1'b0;
         if (bus.flush) state <= IDLE;
         else case (state)
            IDLE: if (bus.start) begin
               mul <= !bus.MDCon[1];
               sa <= sgn && bus.DataA[WIDTH-1];
               sb <= sgn && bus.DataB[WIDTH-1];
               dz <= bus.MDCon[1] && bus.DataB == '0;
               ov <= bus.MDCon == 2'b10 && bus.DataA == {1'b1, {(WIDTH-1){1'b0}}} && bus.DataB == '1;
               acc <= {{WIDTH{1'b0}}, abs_a};
               b <= abs_b;
               counter <= '0;
               state <= bus.MDCon[1] && bus.DataB == '0 ? FINISH : CALC;
            end
            CALC: begin
               acc <= mul ? {sum, acc[WIDTH-1:1]}
                          : {sum[WIDTH] ? x[WIDTH-1:0] : sum[WIDTH-1:0], acc[WIDTH-2:0], !sum[WIDTH]};
               if (counter == CW'(WIDTH-1)) state <= FINISH;
               else counter <= counter + CW'(1);
            end
            FINISH: if (dz && counter == '0) counter <= CW'(1);
            else begin
               bus.hi <= mul ? prod[2*WIDTH-1:WIDTH] : rem;
               bus.lo <= mul ? prod[WIDTH-1:0] : quo;
               bus.Flag <= Flag_Width'({ov, dz});
               bus.done <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed checks of latency, results, flags, flush and reset for muldiv_sequencer
module tb_muldiv_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int vectors = 0;
   int errors = 0;
   muldiv_sequencer_if #(.WIDTH(32), .Flag_Width(3)) bus ();
   muldiv_sequencer #(.WIDTH(32), .Flag_Width(3)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] md, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] eh, input logic [31:0] el, input logic [2:0] ef);
      logic ok;
      bus.start = 1'b1;
      bus.MDCon = md;
      bus.DataA = a;
      bus.DataB = b;
      tick();
      bus.start = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < lat; i++) begin
         if (i > 0) tick();
         if (!(bus.busy === 1'b1 && bus.done === 1'b0)) ok = 1'b0;
      end
      check({tag, "_busy_window"}, ok, 1);
      tick();
      check({tag, "_done"}, bus.done, 1);
      check({tag, "_busy_low"}, bus.busy, 0);
      check({tag, "_hi"}, bus.hi, eh);
      check({tag, "_lo"}, bus.lo, el);
      check({tag, "_flag"}, bus.Flag, ef);
      tick();
      check({tag, "_done_pulse"}, bus.done, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic ok;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.MDCon = 2'b00;
      bus.DataA = '0;
      bus.DataB = '0;
      tick();
      tick();
      reset = 1'b0;
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_hi", bus.hi, 0);
      check("rst_lo", bus.lo, 0);
      check("rst_flag", bus.Flag, 0);

      run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'd2, 33, 32'h00000001, 32'hFFFFFFFE, 3'b000);
      run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd5, 33, 32'hFFFFFFFF, 32'hFFFFFFF1, 3'b000);
      run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 3'b000);
      run_op("div_negdivisor", 2'b10, 32'd7, 32'hFFFFFFFE, 33, 32'h00000001, 32'hFFFFFFFD, 3'b000);
      run_op("divu_zero", 2'b11, 32'd100, 32'd0, 2, 32'h00000064, 32'hFFFFFFFF, 3'b001);
      run_op("div_zero_neg", 2'b10, 32'hFFFFFFFB, 32'd0, 2, 32'hFFFFFFFB, 32'hFFFFFFFF, 3'b001);
      run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 33, 32'h00000000, 32'h80000000, 3'b010);

      // start held high across a whole DIVU; only the done cycle may accept the next op
      bus.start = 1'b1;
      bus.MDCon = 2'b11;
      bus.DataA = 32'd100;
      bus.DataB = 32'd7;
      tick();
      bus.MDCon = 2'b01;
      bus.DataA = 32'd3;
      bus.DataB = 32'd4;
      ok = 1'b1;
      for (int i = 0; i < 33; i++) begin
         if (i > 0) tick();
         if (!(bus.busy === 1'b1 && bus.done === 1'b0)) ok = 1'b0;
      end
      check("b2b_busy_window", ok, 1);
      tick();
      check("b2b_done", bus.done, 1);
      check("b2b_lo", bus.lo, 14);
      check("b2b_hi", bus.hi, 2);
      tick();
      bus.start = 1'b0;
      check("b2b_second_busy", bus.busy, 1);
      check("b2b_second_nodone", bus.done, 0);
      for (int i = 0; i < 32; i++) tick();
      check("b2b_second_pre", bus.done, 0);
      tick();
      check("b2b_second_done", bus.done, 1);
      check("b2b_second_lo", bus.lo, 12);
      check("b2b_second_hi", bus.hi, 0);

      bus.start = 1'b1;
      bus.MDCon = 2'b01;
      bus.DataA = 32'd6;
      bus.DataB = 32'd7;
      tick();
      bus.start = 1'b0;
      for (int i = 1; i < 10; i++) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check("flush_busy", bus.busy, 0);
      check("flush_done", bus.done, 0);
      check("flush_lo_hold", bus.lo, 12);
      check("flush_hi_hold", bus.hi, 0);
      ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) ok = 1'b0;
      end
      check("flush_quiet", ok, 1);
      run_op("multu_fresh", 2'b01, 32'd6, 32'd7, 33, 32'h00000000, 32'd42, 3'b000);

      bus.start = 1'b1;
      bus.flush = 1'b1;
      bus.MDCon = 2'b00;
      bus.DataA = 32'd5;
      bus.DataB = 32'd5;
      tick();
      bus.start = 1'b0;
      bus.flush = 1'b0;
      check("idle_flush_drop", bus.busy, 0);
      for (int i = 0; i < 40; i++) tick();
      check("idle_flush_lo", bus.lo, 42);

      bus.start = 1'b1;
      bus.MDCon = 2'b10;
      bus.DataA = 32'd1000;
      bus.DataB = 32'd3;
      tick();
      bus.start = 1'b0;
      for (int i = 1; i < 20; i++) tick();
      reset = 1'b1;
      bus.start = 1'b1;
      tick();
      reset = 1'b0;
      bus.start = 1'b0;
      check("midrst_busy", bus.busy, 0);
      check("midrst_done", bus.done, 0);
      check("midrst_hi", bus.hi, 0);
      check("midrst_lo", bus.lo, 0);
      check("midrst_flag", bus.Flag, 0);
      ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) ok = 1'b0;
      end
      check("midrst_no_start", ok, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle iterative multiply/divide engine beside the single-cycle ALU in the EX stage.
- Executes MIPS MULT/MULTU/DIV/DIVU and holds the HI/LO results.
- The hazard unit stalls the pipeline on busy.
- Uses one shared 33-bit add/subtract datapath, iterated over 32 cycles, so the ALU critical path is unaffected.

Parameters:
- WIDTH, 32, operand width; shift counter is clog2(WIDTH) bits.
- Flag_Width, 3, flag bus width, encoded {Underflow, Overflow, div. by Zero}.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- MDCon  input  2  op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- DataA  input  WIDTH  multiplicand/dividend; sampled with start.
- DataB  input  WIDTH  multiplier/divisor; sampled with start.
- flush  input  1  pipeline flush; cancels the operation in flight.
- busy  output  1  high while not IDLE.
- done  output  1  one-cycle pulse when hi/lo/Flag update.
- hi  output  WIDTH  MULT: product[63:32]; DIV: remainder.
- lo  output  WIDTH  MULT: product[31:0]; DIV: quotient.
- Flag  output  Flag_Width  {Underflow, Overflow, div. by Zero}; Underflow tied 0.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, busy=0, done=0, hi=0, lo=0, Flag=000, counter=0. Reset wins over start/flush in the same cycle. Reset mid-operation abandons it with no done.
- States: IDLE, CALC, FINISH.
- IDLE: on start=1 at edge k:
  - Latch op.
  - Signed ops: latch |DataA|, |DataB| and sign bits. Unsigned ops: latch raw values.
  - Go to CALC, counter=0.
  - Exception: DIV/DIVU with DataB==0 goes directly to FINISH.
- CALC: one iteration per cycle, 32 cycles (counter 0..31).
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract with 33-bit subtract; quotient bit = no-borrow.
  - After counter==31, go to FINISH.
- FINISH (one cycle): write hi/lo/Flag at the edge leaving FINISH, assert done for exactly that following cycle, return to IDLE.
  - Normal latency: start at edge k -> done high in the cycle after edge k+33, with hi/lo valid in that same cycle.
  - Divide-by-zero latency: done in the cycle after edge k+2.
- Sign correction (signed ops only):
  - Product negated (64-bit two's complement) if the signs differ.
  - Quotient negated if the signs differ.
  - Remainder takes the dividend's sign.
- Divide by zero: lo=all ones, hi=DataA unchanged, Flag=001.
- DIV overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, Flag=010, normal latency.
- All other completions: Flag=000. MULT never sets Overflow (64-bit result is exact).
- hi/lo/Flag hold their values until the next completion. They do not change on start, flush or while busy.
- start while busy: ignored, not queued.
- start and done in the same cycle: done is high only when the state is IDLE, so the start is accepted.
- flush in CALC or FINISH: next edge goes to IDLE, busy=0, no done, hi/lo/Flag unchanged.
- flush in IDLE with start=1: flush wins and the start is dropped.
- busy timing: rises in the cycle after start is accepted, falls in the cycle done is high.
- Counter wraps only by the state change; no overrun past 31.

Test Plan:
- MULTU DataA=0xFFFFFFFF, DataB=2, start at edge 0 -> busy 1 for 33 cycles, then done pulse with hi=0x00000001, lo=0xFFFFFFFE, Flag=000.
- MULT DataA=0xFFFFFFFD (-3), DataB=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1 (-15). DIV -7/2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU DataA=100, DataB=0 -> done in the cycle after edge 2, hi=0x00000064, lo=0xFFFFFFFF, Flag=001. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, Flag=010.
- Back-to-back DIVU 100/7 then a second start held high continuously -> first done gives lo=14, hi=2. The start pulses raised while busy are ignored; the second op is accepted only in the done cycle.
- MULTU 6*7 with flush at cycle 10 -> busy falls the next cycle, no done, hi/lo keep prior values. A fresh MULTU 6*7 then gives lo=42, hi=0.
- reset asserted at cycle 20 of a DIV -> all outputs 0 the next cycle. A start in the same cycle as reset is not accepted.
